// File: rtl/kt_pkg.sv
// Shared definitions for the KT sequential control unit: opcode encodings,
// FSM state type and the decoded-instruction bundle.
package kt_pkg;

  // Load/store opcodes occupy ir[7:5]; the low five bits are the RAM address.
  localparam logic [2:0] OP_LDA    = 3'b000;
  localparam logic [2:0] OP_LDB    = 3'b001;
  localparam logic [2:0] OP_STA    = 3'b010;

  // Immediate-carrying opcodes occupy ir[7:4]; ir[3:0] is the immediate.
  localparam logic [3:0] OP_LOW    = 4'b0110;
  localparam logic [3:0] OP_HIGH   = 4'b0111;
  localparam logic [3:0] OP_ALU    = 4'b1000;
  localparam logic [3:0] OP_JFWD   = 4'b1001;
  localparam logic [3:0] OP_JBACK  = 4'b1010;
  localparam logic [3:0] OP_SHIFTB = 4'b1011;
  localparam logic [3:0] OP_JBZ    = 4'b1100;

  // HALT is a full-byte match; the rest of the 1111xxxx space is NOP.
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // One-hot operation class plus the 4-bit immediate. No flag set means NOP.
  typedef struct packed {
    logic       lda;
    logic       ldb;
    logic       sta;
    logic       low;
    logic       high;
    logic       alu;
    logic       jfwd;
    logic       jback;
    logic       shiftb;
    logic       jbz;
    logic       halt;
    logic [3:0] imm;
  } dec_t;

endpackage

// File: rtl/kt_decode.sv
// Purely combinational instruction decoder: instruction register in,
// one-hot operation class flags and the low-nibble immediate out.
import kt_pkg::*;

module kt_decode (
  input  logic [7:0] ir,
  output dec_t       dec
);

  // Each class is a disjoint bit-pattern match, so at most one flag is set.
  assign dec.lda    = (ir[7:5] == OP_LDA);
  assign dec.ldb    = (ir[7:5] == OP_LDB);
  assign dec.sta    = (ir[7:5] == OP_STA);
  assign dec.low    = (ir[7:4] == OP_LOW);
  assign dec.high   = (ir[7:4] == OP_HIGH);
  assign dec.alu    = (ir[7:4] == OP_ALU);
  assign dec.jfwd   = (ir[7:4] == OP_JFWD);
  assign dec.jback  = (ir[7:4] == OP_JBACK);
  assign dec.shiftb = (ir[7:4] == OP_SHIFTB);
  assign dec.jbz    = (ir[7:4] == OP_JBZ);
  assign dec.halt   = (ir == OP_HALT);
  assign dec.imm    = ir[3:0];

endmodule

// File: rtl/kt_seq_control.sv
// KT sequential control unit: fetch/execute FSM owning the program counter,
// instruction register and B register, with ready handshakes toward the
// instruction ROM and data RAM.
import kt_pkg::*;

module kt_seq_control #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        instr_i,
  input  logic              instr_valid_i,
  output logic              fetch_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [4:0]        ram_addr_o,
  output logic              ram_rd_o,
  input  logic              ram_ready_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_wr_o,
  output logic              load_a_o,
  output logic              load_r_o,
  output logic [3:0]        alu_op_o,
  input  logic              zero_i,
  output logic [DATA_W-1:0] b_o,
  output logic              halted_o
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [7:0]        ir, ir_nxt;
  logic [DATA_W-1:0] b, b_nxt;
  dec_t              dec;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   imm_pc;

  kt_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // All PC arithmetic is PC_W wide, so wrap-around is implicit.
  assign pc_inc = pc + 1'b1;
  assign imm_pc = PC_W'(dec.imm);

  // Next-state, next-register and strobe decode for the fetch/execute FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    b_nxt     = b;
    fetch_o   = 1'b0;
    ram_rd_o  = 1'b0;
    ram_wr_o  = 1'b0;
    load_a_o  = 1'b0;
    load_r_o  = 1'b0;
    halted_o  = 1'b0;

    case (state)
      ST_FETCH: begin
        fetch_o = 1'b1;
        if (instr_valid_i) begin
          ir_nxt    = instr_i;
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        pc_nxt    = pc_inc;
        state_nxt = ST_FETCH;
        if (dec.lda || dec.ldb) begin
          // The PC advances only once the load completes in MEM.
          ram_rd_o  = 1'b1;
          pc_nxt    = pc;
          state_nxt = ST_MEM;
        end
        if (dec.sta)    ram_wr_o = 1'b1;
        if (dec.alu)    load_r_o = 1'b1;
        if (dec.low)    b_nxt[3:0] = dec.imm;
        if (dec.high)   b_nxt[DATA_W-1 -: 4] = dec.imm;
        if (dec.shiftb) b_nxt = {b[DATA_W-5:0], dec.imm};
        if (dec.jfwd)   pc_nxt = pc_inc + imm_pc;
        if (dec.jback)  pc_nxt = pc - imm_pc;
        if (dec.jbz && zero_i) pc_nxt = pc - imm_pc;
        if (dec.halt) begin
          pc_nxt    = pc;
          state_nxt = ST_HALT;
        end
      end

      ST_MEM: begin
        // Address comes straight from ir, so it is held for the whole wait.
        ram_rd_o = 1'b1;
        if (ram_ready_i) begin
          load_a_o  = dec.lda;
          if (dec.ldb) b_nxt = ram_data_i;
          pc_nxt    = pc_inc;
          state_nxt = ST_FETCH;
        end
      end

      ST_HALT: begin
        halted_o = 1'b1;
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // State, PC, IR and B registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    if (rst_i) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      b     <= b_nxt;
    end
  end

  assign pc_o       = pc;
  assign ram_addr_o = ir[4:0];
  assign alu_op_o   = ir[3:0];
  assign b_o        = b;

endmodule

// File: tb/tb_kt_seq_control.sv
// Bench for kt_seq_control: two instances (DATA_W=8 and DATA_W=16) share
// stimulus. An instruction-level model tracks PC, IR and B and publishes the
// expected outputs for each cycle; one process compares them at negedge.
module tb_kt_seq_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        instr_valid;
  logic        ram_ready;
  logic        zero;
  logic [7:0]  instr;
  logic [15:0] ram_data;

  logic        f8, rd8, wr8, la8, lr8, h8;
  logic [7:0]  pc8;
  logic [4:0]  ad8;
  logic [3:0]  op8;
  logic [7:0]  b8;

  logic        f16, rd16, wr16, la16, lr16, h16;
  logic [7:0]  pc16;
  logic [4:0]  ad16;
  logic [3:0]  op16;
  logic [15:0] b16;

  kt_seq_control #(.DATA_W(8), .PC_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .instr_valid_i(instr_valid),
    .fetch_o(f8), .pc_o(pc8), .ram_addr_o(ad8), .ram_rd_o(rd8),
    .ram_ready_i(ram_ready), .ram_data_i(ram_data[7:0]), .ram_wr_o(wr8),
    .load_a_o(la8), .load_r_o(lr8), .alu_op_o(op8), .zero_i(zero),
    .b_o(b8), .halted_o(h8)
  );

  kt_seq_control #(.DATA_W(16), .PC_W(8)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .instr_valid_i(instr_valid),
    .fetch_o(f16), .pc_o(pc16), .ram_addr_o(ad16), .ram_rd_o(rd16),
    .ram_ready_i(ram_ready), .ram_data_i(ram_data), .ram_wr_o(wr16),
    .load_a_o(la16), .load_r_o(lr16), .alu_op_o(op16), .zero_i(zero),
    .b_o(b16), .halted_o(h16)
  );

  // Architectural model state.
  logic [7:0]  m_pc, m_ir, m_b8;
  logic [15:0] m_b16;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  logic        e_fetch, e_rd, e_wr, e_la, e_lr, e_halt;
  logic [7:0]  e_pc;
  logic [4:0]  e_addr;
  logic [3:0]  e_op;
  logic [7:0]  e_b8;
  logic [15:0] e_b16;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("fetch8",   32'(f8),    32'(e_fetch));
      check("fetch16",  32'(f16),   32'(e_fetch));
      check("pc8",      32'(pc8),   32'(e_pc));
      check("pc16",     32'(pc16),  32'(e_pc));
      check("rd8",      32'(rd8),   32'(e_rd));
      check("rd16",     32'(rd16),  32'(e_rd));
      check("wr8",      32'(wr8),   32'(e_wr));
      check("wr16",     32'(wr16),  32'(e_wr));
      check("lda8",     32'(la8),   32'(e_la));
      check("lda16",    32'(la16),  32'(e_la));
      check("ldr8",     32'(lr8),   32'(e_lr));
      check("ldr16",    32'(lr16),  32'(e_lr));
      check("halt8",    32'(h8),    32'(e_halt));
      check("halt16",   32'(h16),   32'(e_halt));
      check("addr8",    32'(ad8),   32'(e_addr));
      check("addr16",   32'(ad16),  32'(e_addr));
      check("aluop8",   32'(op8),   32'(e_op));
      check("aluop16",  32'(op16),  32'(e_op));
      check("b8",       32'(b8),    32'(e_b8));
      check("b16",      32'(b16),   32'(e_b16));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unsampled inputs get random values so ignoring them is exercised.
  task automatic rand_inputs();
    instr_valid = 1'($urandom);
    instr       = 8'($urandom);
    ram_ready   = 1'($urandom);
    zero        = 1'($urandom);
    ram_data    = 16'($urandom);
  endtask

  task automatic expect_idle();
    e_fetch = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_la = 1'b0; e_lr = 1'b0; e_halt = 1'b0;
    e_pc    = m_pc;
    e_addr  = m_ir[4:0];
    e_op    = m_ir[3:0];
    e_b8    = m_b8;
    e_b16   = m_b16;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rand_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_pc = '0; m_ir = '0; m_b8 = '0; m_b16 = '0;
    check("rst_fetch",  32'(f8),   32'd1);
    check("rst_pc",     32'(pc16), 32'd0);
    check("rst_rd",     32'(rd8),  32'd0);
    check("rst_halted", 32'(h16),  32'd0);
    check("rst_b16",    32'(b16),  32'd0);
    chk_en = 1'b1;
  endtask

  // One instruction: fw idle fetch cycles, EXEC, then mw idle MEM cycles for
  // loads. With abort set the load never completes (caller resets mid-MEM).
  task automatic run(input logic [7:0] op, input int fw, input int mw,
                     input logic z, input logic [15:0] d, input bit abort = 1'b0);
    logic [3:0] k;
    logic [7:0] next_pc;
    bit         ld;
    for (int i = 0; i <= fw; i++) begin
      rand_inputs();
      instr_valid = (i == fw);
      if (i == fw) instr = op;
      expect_idle();
      e_fetch = 1'b1;
      step();
    end
    m_ir    = op;
    k       = op[3:0];
    next_pc = m_pc + 8'd1;
    ld      = (op[7:6] == 2'b00);
    rand_inputs();
    zero = z;
    expect_idle();
    if (op == 8'hFF) next_pc = m_pc;
    else if (ld) e_rd = 1'b1;
    else if (op[7:5] == 3'b010) e_wr = 1'b1;
    else begin
      case (op[7:4])
        4'h6: begin m_b8 = (m_b8 & 8'hF0) | 8'(k); m_b16 = (m_b16 & 16'hFFF0) | 16'(k); end
        4'h7: begin m_b8 = {k, m_b8[3:0]}; m_b16 = {k, m_b16[11:0]}; end
        4'h8: e_lr = 1'b1;
        4'h9: next_pc = m_pc + 8'd1 + 8'(k);
        4'hA: next_pc = m_pc - 8'(k);
        4'hB: begin m_b8 = {m_b8[3:0], k}; m_b16 = {m_b16[11:0], k}; end
        4'hC: if (z) next_pc = m_pc - 8'(k);
        default: ;
      endcase
    end
    step();
    if (ld) begin
      for (int i = 0; i <= mw; i++) begin
        rand_inputs();
        ram_ready = (i == mw) && !abort;
        if (i == mw) ram_data = d;
        expect_idle();
        e_rd = 1'b1;
        e_la = ram_ready && !op[5];
        step();
      end
      if (abort) return;
      if (op[5]) begin m_b8 = d[7:0]; m_b16 = d; end
    end
    m_pc = next_pc;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      expect_idle();
      e_halt = 1'b1;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] op;
    int         r;
    rst_i = 1'b1;
    rand_inputs();
    step();
    step();
    do_reset();

    // B built from two nibble immediates.
    run(8'h65, 0, 0, 1'b0, 16'h0);
    run(8'h7A, 0, 0, 1'b0, 16'h0);
    check("t1_b8",  32'(b8),  32'h00A5);
    check("t1_b16", 32'(b16), 32'hA005);
    check("t1_pc",  32'(pc8), 32'd2);

    // Loads with a slow RAM.
    do_reset();
    run(8'h03, 0, 3, 1'b0, 16'h003C);
    check("t2_pc",   32'(pc8), 32'd1);
    check("t2_addr", 32'(ad8), 32'd3);
    run(8'h23, 1, 3, 1'b0, 16'h003C);
    check("t2_b8",  32'(b8),  32'h3C);
    check("t2_b16", 32'(b16), 32'h003C);

    // Shift-in immediates at both widths.
    do_reset();
    run(8'hB1, 0, 0, 1'b0, 16'h0);
    run(8'hB2, 0, 0, 1'b0, 16'h0);
    run(8'hB3, 0, 0, 1'b0, 16'h0);
    run(8'hB4, 0, 0, 1'b0, 16'h0);
    check("t3_shift16", 32'(b16), 32'h1234);
    check("t3_shift8",  32'(b8),  32'h34);
    run(8'h6F, 0, 0, 1'b0, 16'h0);
    check("t3_low16", 32'(b16), 32'h123F);

    // Jumps and wrap-around.
    do_reset();
    run(8'hA2, 0, 0, 1'b0, 16'h0);
    check("t4_back_wrap", 32'(pc8), 32'hFE);
    run(8'h93, 0, 0, 1'b0, 16'h0);
    check("t4_fwd_wrap", 32'(pc8), 32'h02);
    do_reset();
    run(8'hD0, 0, 0, 1'b0, 16'h0);
    run(8'hA4, 0, 0, 1'b0, 16'h0);
    check("t4_back4", 32'(pc8), 32'hFD);
    do_reset();
    run(8'h99, 0, 0, 1'b0, 16'h0);
    check("t4_to10", 32'(pc8), 32'd10);
    run(8'hC2, 0, 0, 1'b1, 16'h0);
    check("t4_jbz_taken", 32'(pc8), 32'd8);
    run(8'h91, 0, 0, 1'b0, 16'h0);
    run(8'hC2, 0, 0, 1'b0, 16'h0);
    check("t4_jbz_not", 32'(pc8), 32'd11);

    // Store, ALU and an undefined opcode.
    run(8'h45, 2, 0, 1'b0, 16'h0);
    run(8'h85, 0, 0, 1'b0, 16'h0);
    run(8'hD0, 0, 0, 1'b1, 16'h0);
    check("t5_pc", 32'(pc8), 32'd14);

    // HALT freezes the core; reset mid-MEM restarts it.
    do_reset();
    run(8'hD0, 0, 0, 1'b0, 16'h0);
    run(8'hE7, 0, 0, 1'b0, 16'h0);
    run(8'hFF, 0, 0, 1'b0, 16'h0);
    halt_cycles(20);
    check("t6_halt_pc",    32'(pc8), 32'd2);
    check("t6_halt_fetch", 32'(f16), 32'd0);
    do_reset();
    run(8'h05, 0, 0, 1'b0, 16'h0);
    run(8'h07, 0, 2, 1'b0, 16'h0, 1'b1);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 99));
      op = 8'($urandom_range(0, 254));
      if (r < 2) begin
        run(8'hFF, int'($urandom_range(0, 2)), 0, 1'b0, 16'h0);
        halt_cycles(int'($urandom_range(1, 5)));
        do_reset();
      end else if (r < 4) begin
        op = {2'b00, 1'($urandom), 5'($urandom)};
        run(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b1);
        do_reset();
      end else begin
        run(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
            1'($urandom), 16'($urandom));
      end
    end

    chk_en = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kt_seq_control.md
Name: kt_seq_control

Overview:
- Parametrised, sequential successor to the KT8 combinational instruction decoder.
- Owns the program counter, instruction register and B register.
- Runs a fetch/execute FSM with a ready handshake on instruction memory and data RAM.
- Adds relative jumps, a conditional jump, a B shift-in immediate and HALT. Sits between instruction ROM, data RAM, the A/R registers and the ALU.

Parameters:
- DATA_W, 8, data/B register width; even, >= 8.
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- instr_i  in  8  instruction from ROM
- instr_valid_i  in  1  instr_i valid for the current pc_o
- fetch_o  out  1  instruction request
- pc_o  out  PC_W  program counter
- ram_addr_o  out  5  RAM address (ir[4:0])
- ram_rd_o  out  1  RAM read request
- ram_ready_i  in  1  ram_data_i valid
- ram_data_i  in  DATA_W  RAM read data
- ram_wr_o  out  1  RAM write strobe (A is written externally)
- load_a_o  out  1  A captures ram_data_i this cycle
- load_r_o  out  1  R captures ALU result this cycle
- alu_op_o  out  4  ir[3:0]
- zero_i  in  1  ALU zero flag
- b_o  out  DATA_W  B register
- halted_o  out  1  core halted

Behaviour:
- Reset (rst_i=1 at a clock edge): state=FETCH, pc=0, ir=0, B=0. All strobes 0, halted_o=0. Reset overrides every state, including MEM and HALT.
- States: FETCH, EXEC, MEM, HALT.
- FETCH:
  - fetch_o=1; pc_o stable.
  - When instr_valid_i=1: ir<=instr_i, go to EXEC. Otherwise stay; no limit on the wait.
- EXEC: one cycle; decode ir as below. Unless stated otherwise: pc<=pc+1, then go to FETCH.
  - 000aaaaa LDA: ram_rd_o=1, go to MEM.
  - 001aaaaa LDB: ram_rd_o=1, go to MEM.
  - 010aaaaa STA: ram_wr_o=1 for exactly this cycle.
  - 0110dddd LOWBITS: B[3:0]<=d; upper bits kept.
  - 0111dddd HIGHBITS: B[DATA_W-1:DATA_W-4]<=d; other bits kept.
  - 1000xxxx ALU: load_r_o=1; alu_op_o=x.
  - 1001dddd JFWD: pc<=pc+d+1.
  - 1010dddd JBACK: pc<=pc-d (d=0 is a self-loop).
  - 1011dddd SHIFTB: B<={B[DATA_W-5:0], d}.
  - 1100dddd JBZ: if zero_i=1 (sampled in EXEC) then pc<=pc-d, else pc<=pc+1.
  - 11111111 HALT: go to HALT; pc unchanged.
  - All other encodings: NOP (pc+1).
- MEM:
  - ram_rd_o=1 and ram_addr_o held until ram_ready_i=1.
  - On the ready cycle: LDA pulses load_a_o=1; LDB does B<=ram_data_i. Then pc+1, go to FETCH.
  - ram_ready_i=1 already in the first MEM cycle completes the load in that cycle.
- HALT: halted_o=1; no strobes; only reset exits.
- ram_addr_o=ir[4:0] and alu_op_o=ir[3:0] at all times (don't-care outside use).
- All other strobes are 0 unless asserted above.
- PC arithmetic is modulo 2^PC_W: jumps and increments wrap silently (pc=2^PC_W-1, +1 -> 0; pc=0, JBACK 2 -> 2^PC_W-2).
- Latency: minimum 2 cycles per instruction (FETCH, EXEC); loads take 3 or more.
- Inputs are ignored outside the states that sample them: instr_valid_i outside FETCH, ram_ready_i outside MEM, zero_i outside EXEC of JBZ.

Decomposition:
- Package kt_pkg holds:
  - opcode localparams (OP_LDA=3'b000, OP_LDB, OP_STA, OP_LOW=4'b0110, OP_HIGH, OP_ALU, OP_JFWD, OP_JBACK, OP_SHIFTB, OP_JBZ, OP_HALT=8'hFF);
  - the state enum.
- One natural sub-module: kt_decode, purely combinational. Maps ir to one-hot op-class flags plus the immediate.
- The FSM, PC and B stay in kt_seq_control.

Test Plan:
1. Reset, then ROM {0x65, 0x7A} (valid immediately), DATA_W=8 -> after 4 cycles b_o=0xA5, pc_o=2.
2. LDA 0x03 with ram_ready_i held low 3 cycles, then high with data 0x3C:
   - ram_rd_o high for 4 MEM cycles; load_a_o single pulse on the ready cycle; ram_addr_o=3; pc_o+1.
   - Repeat with LDB -> b_o=0x3C.
3. DATA_W=16, SHIFTB 1, 2, 3, 4 -> b_o=0x1234; then LOWBITS F -> 0x123F.
4. Jumps at PC_W=8:
   - pc=0xFE, JFWD 3 -> pc_o=0x02.
   - pc=1, JBACK 4 -> 0xFD.
   - JBZ 2 at pc=10: zero_i=1 -> 8; zero_i=0 -> 11.
5. STA -> ram_wr_o exactly one cycle. ALU 0x85 -> load_r_o one cycle with alu_op_o=5. Opcode 0xD0 -> no strobes, pc+1.
6. HALT -> halted_o=1, pc frozen, fetch_o=0 for 20 cycles. rst_i asserted mid-MEM -> next cycle state FETCH, pc=0, ram_rd_o=0.
